// File: rtl/fir_result_buffer_pkg.sv
// rtl/fir_result_buffer_pkg.sv - shared FIR datapath types for the result buffer
package fir_result_buffer_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int NUM_REGS   = 8;
    typedef logic signed [DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/fir_result_buffer_if.sv
// rtl/fir_result_buffer_if.sv - result stream in/out handshake bundle
interface fir_result_buffer_if;
    import fir_result_buffer_pkg::*;

    sample_t inData;
    logic    inValid;
    sample_t outData;
    logic    outValid;
    logic    outReady;

    modport master (output inData, output inValid, output outReady,
                    input outData, input outValid);
    modport slave  (input inData, input inValid, input outReady,
                    output outData, output outValid);
endinterface

// File: rtl/fir_result_buffer_sync_fifo.sv
// rtl/fir_result_buffer_sync_fifo.sv - show-ahead FIFO with explicit occupancy count
module fir_result_buffer_sync_fifo
    import fir_result_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  sample_t          wdata_i,
    output sample_t          rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    sample_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Storage is not reset, so the head is masked to keep outData at zero while empty.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fir_result_buffer.sv
// rtl/fir_result_buffer.sv - decimating, overflow-counting result FIFO behind the FIR MAC
module fir_result_buffer
    import fir_result_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DECIM_W-1:0]         decimFactor,
    fir_result_buffer_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           dropCount,
    output logic                       overflow
);
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               keep, push, pop, drop, dec_wrap, clear;

    assign clear = rst || flush;
    assign keep  = bus.inValid && (dec_cnt_q == '0);
    assign pop   = bus.outValid && bus.outReady;
    assign push  = keep && !flush;
    assign drop  = keep && full && !pop;
    // N of 0 or 1 keeps everything; >= lets a lowered N take effect on the next result.
    assign dec_wrap = (decimFactor <= DECIM_W'(1)) || (dec_cnt_q >= decimFactor - 1'b1);

    always_comb begin
        dec_cnt_d  = dec_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (bus.inValid) dec_cnt_d = dec_wrap ? '0 : dec_cnt_q + 1'b1;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            dec_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    fir_result_buffer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.inData),
        .rdata_o (bus.outData),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.outValid = !empty;
    assign dropCount    = drop_cnt_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_fir_result_buffer.sv
// tb/tb_fir_result_buffer.sv - directed self-checking bench for fir_result_buffer
module tb_fir_result_buffer;
    import fir_result_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, flush;
    logic [3:0] decimFactor;
    logic [3:0] level;
    logic       full, empty, overflow;
    logic [7:0] dropCount;
    int         total = 0;
    int         bad = 0;
    sample_t    got[$];

    fir_result_buffer_if bus();

    fir_result_buffer #(.DEPTH(8), .DECIM_W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .decimFactor (decimFactor),
        .bus         (bus),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .dropCount   (dropCount),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Records the head if it is popped at the coming edge, then advances one cycle.
    task automatic step();
        if (bus.outValid && bus.outReady) got.push_back(bus.outData);
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input int v);
        bus.inData  = sample_t'(v);
        bus.inValid = 1'b1;
        step();
    endtask

    initial begin
        int exp4[8];
        int exp5[8];
        rst = 1'b1; flush = 1'b0; decimFactor = 4'd1;
        bus.inData = '0; bus.inValid = 1'b0; bus.outReady = 1'b0;

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            flush = 1'($urandom); decimFactor = 4'($urandom);
            bus.inData = sample_t'($urandom); bus.inValid = 1'($urandom);
            bus.outReady = 1'($urandom);
            step();
            check_val("rst_level", int'(level), 0);
            check_val("rst_empty", int'(empty), 1);
            check_val("rst_full", int'(full), 0);
            check_val("rst_outValid", int'(bus.outValid), 0);
            check_val("rst_outData", int'(bus.outData), 0);
            check_val("rst_dropCount", int'(dropCount), 0);
            check_val("rst_overflow", int'(overflow), 0);
        end
        rst = 1'b0; flush = 1'b0; bus.inValid = 1'b0; bus.outReady = 1'b0;
        decimFactor = 4'd1;
        step();

        // 2. passthrough
        bus.outReady = 1'b1;
        push_val(5);
        check_val("pt_valid0", int'(bus.outValid), 1);
        check_val("pt_data0", int'(bus.outData), 5);
        check_val("pt_level0", int'(level), 1);
        push_val(-3);
        check_val("pt_data1", int'(bus.outData), -3);
        check_val("pt_level1", int'(level), 1);
        push_val(7);
        check_val("pt_data2", int'(bus.outData), 7);
        check_val("pt_level2", int'(level), 1);
        bus.inValid = 1'b0;
        step();
        check_val("pt_empty", int'(empty), 1);
        check_val("pt_drop", int'(dropCount), 0);

        // 3. decimation by 3, then keep-all
        got.delete();
        decimFactor = 4'd3;
        for (int v = 1; v <= 9; v++) push_val(v);
        bus.inValid = 1'b0;
        repeat (3) step();
        check_val("dec3_count", got.size(), 3);
        if (got.size() == 3) begin
            check_val("dec3_a", int'(got[0]), 1);
            check_val("dec3_b", int'(got[1]), 4);
            check_val("dec3_c", int'(got[2]), 7);
        end
        got.delete();
        decimFactor = 4'd0;
        for (int v = 20; v <= 22; v++) push_val(v);
        bus.inValid = 1'b0;
        repeat (3) step();
        check_val("dec0_count", got.size(), 3);
        if (got.size() == 3) begin
            check_val("dec0_a", int'(got[0]), 20);
            check_val("dec0_b", int'(got[1]), 21);
            check_val("dec0_c", int'(got[2]), 22);
        end

        // 4. overflow
        decimFactor = 4'd1;
        bus.outReady = 1'b0;
        for (int v = 10; v <= 19; v++) push_val(v);
        bus.inValid = 1'b0;
        step();
        check_val("ovf_level", int'(level), 8);
        check_val("ovf_full", int'(full), 1);
        check_val("ovf_drop", int'(dropCount), 2);
        check_val("ovf_sticky", int'(overflow), 1);
        got.delete();
        bus.outReady = 1'b1;
        repeat (9) step();
        exp4 = '{10, 11, 12, 13, 14, 15, 16, 17};
        check_val("ovf_drain_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check_val($sformatf("ovf_drain%0d", i), int'(got[i]), exp4[i]);
        check_val("ovf_empty", int'(empty), 1);

        // 5. full push + pop in the same cycle
        bus.outReady = 1'b0;
        for (int v = 30; v <= 37; v++) push_val(v);
        bus.inValid = 1'b0;
        step();
        check_val("fpp_pre_level", int'(level), 8);
        check_val("fpp_pre_head", int'(bus.outData), 30);
        got.delete();
        bus.outReady = 1'b1;
        push_val(99);
        bus.inValid = 1'b0;
        bus.outReady = 1'b0;
        check_val("fpp_level", int'(level), 8);
        check_val("fpp_full", int'(full), 1);
        check_val("fpp_drop", int'(dropCount), 2);
        check_val("fpp_head", int'(bus.outData), 31);
        got.delete();
        bus.outReady = 1'b1;
        repeat (9) step();
        exp5 = '{31, 32, 33, 34, 35, 36, 37, 99};
        check_val("fpp_drain_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check_val($sformatf("fpp_drain%0d", i), int'(got[i]), exp5[i]);

        // 6. flush mid-stream, with decimation counter left non-zero
        bus.outReady = 1'b0;
        for (int v = 50; v <= 53; v++) push_val(v);
        decimFactor = 4'd3;
        push_val(60);
        bus.inValid = 1'b0;
        check_val("fl_pre_level", int'(level), 5);
        flush = 1'b1;
        push_val(77);
        flush = 1'b0;
        bus.inValid = 1'b0;
        check_val("fl_level", int'(level), 0);
        check_val("fl_empty", int'(empty), 1);
        check_val("fl_outValid", int'(bus.outValid), 0);
        check_val("fl_drop", int'(dropCount), 0);
        check_val("fl_overflow", int'(overflow), 0);
        for (int v = 41; v <= 43; v++) push_val(v);
        bus.inValid = 1'b0;
        step();
        check_val("fl_dec_level", int'(level), 1);
        check_val("fl_dec_head", int'(bus.outData), 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
